// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// datapath widths, default reset PC / step, and an address-alignment helper.
package instruction_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEF_PC_STEP  = 32'd4;

  // FETCH: request outstanding at pc_q; HOLD: word parked in hold buffer;
  // DROP: old request still completing after a redirect, its data is thrown away.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DROP  = 2'b10
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {pc, instruction} holding register used while the stage register
// is frozen. clear wins over load; synchronous active-low reset.
module fetch_hold_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [ADDR_W-1:0]  pc_d, pc_q;
  logic [INSTR_W-1:0] instr_d, instr_q;

  // Next-entry selection: clear, load, or keep.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      pc_d    = 32'h0000_0000;
      instr_d = 32'h0000_0000;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
    end else begin
      pc_d    = pc_q;
      instr_d = instr_q;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory request
// handshake and produces {pc+step, instruction, valid} for the IF/ID register.
// Optional macro FETCH_STALL_COUNTER_EN adds a saturating stall_cycles output
// counting request cycles that see no acknowledge.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instruction_out,
`ifdef FETCH_STALL_COUNTER_EN
  output logic [31:0]        stall_cycles,
`endif
  output logic               valid_out
);

  fetch_state_e       state_d, state_q;
  logic [ADDR_W-1:0]  pc_d, pc_q;
  logic [ADDR_W-1:0]  drop_addr_d, drop_addr_q;
  logic [ADDR_W-1:0]  out_pc_d, out_pc_q;
  logic [INSTR_W-1:0] out_instr_d, out_instr_q;
  logic               out_valid_d, out_valid_q;
  logic               buf_load, buf_clear;
  logic [ADDR_W-1:0]  buf_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  pc_next;

  assign pc_next = pc_q + PC_STEP;

  // Request is live in FETCH and DROP, and never while reset is held.
  // DROP keeps presenting the abandoned address until its ack arrives.
  assign imem_req  = rst & (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  fetch_hold_buffer u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .pc_in    (pc_next),
    .instr_in (imem_rdata),
    .pc_o     (buf_pc),
    .instr_o  (buf_instr)
  );

  // Next-state, PC and output-register logic; a redirect beats everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    if (branch_taken) begin
      pc_d        = word_align(branch_addr);
      out_valid_d = 1'b0;
      buf_clear   = 1'b1;
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            state_d     = ST_DROP;
            drop_addr_d = pc_q;
          end
        end
        ST_HOLD: state_d = ST_FETCH;
        ST_DROP: begin
          if (imem_ack) state_d = ST_FETCH;
          else          state_d = ST_DROP;
        end
        default: state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (freeze) begin
            if (imem_ack) begin
              buf_load = 1'b1;
              pc_d     = pc_next;
              state_d  = ST_HOLD;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            if (imem_ack) begin
              out_pc_d    = pc_next;
              out_instr_d = imem_rdata;
              out_valid_d = 1'b1;
              pc_d        = pc_next;
            end else begin
              out_valid_d = 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (!freeze) begin
            out_pc_d    = buf_pc;
            out_instr_d = buf_instr;
            out_valid_d = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_ack) state_d = ST_FETCH;
          else          state_d = ST_DROP;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // State, PC and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0000_0000;
      out_pc_q    <= 32'h0000_0000;
      out_instr_q <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pc_out          = out_pc_q;
  assign instruction_out = out_instr_q;
  assign valid_out       = out_valid_q;

`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] stall_d, stall_q;

  // Saturating count of request cycles without an acknowledge.
  always_comb begin
    stall_d = stall_q;
    if (imem_req && !imem_ack) begin
      if (stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
      else                          stall_d = stall_q;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst) stall_q <= 32'h0000_0000;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized freeze/branch/reset/memory-latency traffic, all compared each
// cycle against a transaction-level reference model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ack, imem_req, valid_out;
  logic [31:0] branch_addr, imem_rdata, imem_addr, pc_out, instruction_out;
`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
`ifdef FETCH_STALL_COUNTER_EN
    .stall_cycles    (stall_cycles),
`endif
    .valid_out       (valid_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed, address-dependent word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: PC, at most one parked word, and an "abandoned request" flag.
  logic [31:0] m_pc, m_drop_addr, m_out_pc, m_out_instr, m_stall;
  logic        m_out_valid, m_drop;
  logic [63:0] m_buf[$];
  int          mem_mode;   // 0 zero-wait, 1 two-cycle, 2 random, 3 never ack
  int          wait_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_drop = 1'b0; m_drop_addr = 32'h0;
    m_out_pc = 32'h0; m_out_instr = 32'h0; m_out_valid = 1'b0;
    m_stall = 32'h0; m_buf.delete();
  endtask

  task automatic model_update(input logic r, input logic fr, input logic br,
                              input logic [31:0] ba, input logic ack);
    logic req_now;
    if (!r) begin
      model_reset();
      return;
    end
    req_now = (m_buf.size() == 0);
    if (req_now && !ack && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (br) begin
      if (m_drop) begin
        if (ack) m_drop = 1'b0;
      end else if (m_buf.size() == 0 && !ack) begin
        m_drop = 1'b1;
        m_drop_addr = m_pc;
      end
      m_buf.delete();
      m_pc = ba & 32'hFFFF_FFFC;
      m_out_valid = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (!fr) begin
        {m_out_pc, m_out_instr} = m_buf.pop_front();
        m_out_valid = 1'b1;
      end
    end else if (m_drop) begin
      if (ack) m_drop = 1'b0;
    end else if (ack) begin
      if (fr) m_buf.push_back({m_pc + 32'd4, mem_word(m_pc)});
      else begin
        m_out_pc = m_pc + 32'd4;
        m_out_instr = mem_word(m_pc);
        m_out_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!fr) begin
      m_out_valid = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    logic exp_req;
    exp_req = rst && (m_buf.size() == 0);
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
    check_eq("valid_out", 32'(valid_out), 32'(m_out_valid));
    check_eq("pc_out", pc_out, m_out_pc);
    check_eq("instruction_out", instruction_out, m_out_instr);
`ifdef FETCH_STALL_COUNTER_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  // One clock: check, drive controls, let memory answer, advance the model.
  task automatic step(input logic r, input logic fr, input logic br, input logic [31:0] ba);
    logic        a;
    logic [31:0] d;
    @(negedge clk);
    compare_outputs();
    rst = r; freeze = fr; branch_taken = br; branch_addr = ba;
    #1;
    a = 1'b0;
    if (r && imem_req) begin
      case (mem_mode)
        0:       a = 1'b1;
        1:       a = (wait_cnt >= 1);
        2:       a = ($urandom_range(0, 2) == 0);
        default: a = 1'b0;
      endcase
    end
    d = a ? mem_word(imem_addr) : $urandom();
    imem_ack = a;
    imem_rdata = d;
    model_update(r, fr, br, ba, a);
    if (r && imem_req && !a) wait_cnt++;
    else wait_cnt = 0;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; mem_mode = 0; wait_cnt = 0;
    model_reset();

    // Zero-wait memory: one instruction per cycle.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check_eq("zw_valid", 32'(valid_out), 32'd1);
      check_eq("zw_pc", pc_out, 32'(4 * k));
      check_eq("zw_instr", instruction_out, mem_word(32'(4 * (k - 1))));
      step(1'b1, 1'b0, 1'b0, 32'h0);
    end

    // Two-cycle memory latency.
    mem_mode = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Freeze with the ack in the first frozen cycle.
    mem_mode = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_eq("frz_req", 32'(imem_req), 32'd0);
    check_eq("frz_pc", pc_out, 32'd4);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_eq("frz_rel_pc", pc_out, 32'd8);
    check_eq("frz_rel_instr", instruction_out, mem_word(32'd4));
    step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_eq("frz_next_pc", pc_out, 32'd12);

    // Redirect while a request is outstanding.
    mem_mode = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    mem_mode = 3;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    @(posedge clk); #1;
    check_eq("drop_old_addr", imem_addr, 32'h0);
    check_eq("drop_valid", 32'(valid_out), 32'd0);
    mem_mode = 1;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_eq("drop_new_addr", imem_addr, 32'h0000_0100);
    check_eq("drop_valid2", 32'(valid_out), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_eq("drop_first_pc", pc_out, 32'h0000_0104);
    check_eq("drop_first_instr", instruction_out, mem_word(32'h0000_0100));

    // PC wrap-around.
    mem_mode = 0;
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_eq("wrap_addr1", imem_addr, 32'h0);
    check_eq("wrap_pc_out", pc_out, 32'h0);

    // Reset in the middle of a pending request.
    mem_mode = 3;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_pc", pc_out, 32'd0);
    check_eq("rst_instr", instruction_out, 32'd0);
`ifdef FETCH_STALL_COUNTER_EN
    check_eq("rst_stall", stall_cycles, 32'd0);
`endif
    mem_mode = 0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("rst_restart_addr", imem_addr, 32'h0);

    // Randomized traffic.
    mem_mode = 2;
    for (int i = 0; i < 800; i++) begin
      logic        r, fr, br;
      logic [31:0] ba;
      r  = ($urandom_range(0, 99) != 0);
      fr = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 9) == 0);
      ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      step(r, fr, br, ba);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
